// File: rtl/pio_number_arbiter_if.sv
// Bundle between the number producers, the PIO ports and the arbiter.
// The master side is the producers/software; the slave side is the arbiter.
interface pio_number_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [DATA_W-1:0]         pio_data;
   logic [7:0]                pio_status;
   logic                      ack_toggle;
   logic                      clr_err;

   modport master (
      output req, req_data, ack_toggle, clr_err,
      input  grant, pio_data, pio_status
   );

   modport slave (
      input  req, req_data, ack_toggle, clr_err,
      output grant, pio_data, pio_status
   );
endinterface

// File: rtl/pio_number_arbiter.sv
// Round-robin arbiter that latches one producer's value onto a shared PIO
// input and holds it until software toggles the ack bit or a timeout expires.
//
// state    | meaning
// IDLE     | no value presented; capture the next round-robin winner
// WAIT_ACK | value valid on the PIO; waiting for an ack toggle or timeout
// HOLDOFF  | one cycle with valid low so software sees a gap between values
module pio_number_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 5000000
) (
   input  logic                clk,
   input  logic                reset,
   pio_number_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLDOFF} state_t;

   state_t              state_q, state_d;
   logic [1:0]          rr_q, rr_d;
   logic [23:0]         cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [1:0]          tag_q, tag_d;
   logic                valid_q, valid_d;
   logic                sticky_q, sticky_d;
   logic                seq_q, seq_d;
   logic                ack_q;

   logic                ack_edge;
   logic                timeout_hit;
   logic [3:0]          req_pad;
   logic [3:0]          grant_oh;
   logic                win_vld;
   logic [1:0]          win_idx;
   logic [DATA_W-1:0]   win_data;
   logic [2:0]          cand;

   assign ack_edge    = bus.ack_toggle ^ ack_q;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == 24'(TIMEOUT_CYC - 1));
   assign req_pad     = 4'(bus.req);
   assign grant_oh    = 4'b0001 << win_idx;

   // Scan upward from the rr pointer with wrap; first set request wins.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_data = '0;
      cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = 3'(rr_q) + 3'(k);
         if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
         if (!win_vld && req_pad[cand[1:0]]) begin
            win_vld = 1'b1;
            win_idx = cand[1:0];
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_idx == 2'(k)) win_data = bus.req_data[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      grant_d  = '0;
      data_d   = data_q;
      tag_d    = tag_q;
      valid_d  = valid_q;
      seq_d    = seq_q;
      sticky_d = sticky_q;
      if (bus.clr_err) sticky_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               data_d  = win_data;
               tag_d   = win_idx;
               valid_d = 1'b1;
               seq_d   = ~seq_q;
               grant_d = grant_oh[NUM_REQ-1:0];
               rr_d    = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
               cnt_d   = '0;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            cnt_d = cnt_q + 24'd1;
            // An ack arriving on the timeout cycle still counts as a clean ack.
            if (ack_edge) begin
               valid_d = 1'b0;
               state_d = HOLDOFF;
            end else if (timeout_hit) begin
               valid_d  = 1'b0;
               sticky_d = 1'b1;
               state_d  = HOLDOFF;
            end
         end
         HOLDOFF: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         tag_q    <= '0;
         valid_q  <= 1'b0;
         sticky_q <= 1'b0;
         seq_q    <= 1'b0;
         ack_q    <= bus.ack_toggle;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         tag_q    <= tag_d;
         valid_q  <= valid_d;
         sticky_q <= sticky_d;
         seq_q    <= seq_d;
         ack_q    <= bus.ack_toggle;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.pio_data   = data_q;
   assign bus.pio_status = {seq_q, 3'b000, sticky_q, tag_q, valid_q};
endmodule

// File: tb/tb_pio_number_arbiter.sv
// Directed bench for pio_number_arbiter with a short timeout so the timeout
// and ack/timeout collision paths are reachable in a few cycles.
module tb_pio_number_arbiter;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 16;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   pio_number_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   pio_number_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_W     (DATA_W),
      .TIMEOUT_CYC(8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req = '0;
      bus.clr_err = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.ack_toggle = 1'b1;
      tick();
      tick();
      n_tests++;
      if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %h want 0", bus.grant); end
      n_tests++;
      if (bus.pio_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", bus.pio_data); end
      n_tests++;
      if (bus.pio_status !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h want 00", bus.pio_status); end
      reset = 1'b0;
      tick();
      n_tests++;
      if (bus.pio_status !== 8'h00) begin n_fail++; $display("FAIL reset_idle_status got %h want 00", bus.pio_status); end
   endtask

   task automatic test_single();
      bus.req = 4'b0001;
      bus.req_data = {16'h0, 16'h0, 16'h0, 16'h1234};
      tick();
      n_tests++;
      if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", bus.grant); end
      n_tests++;
      if (bus.pio_data !== 16'h1234) begin n_fail++; $display("FAIL single_data got %h want 1234", bus.pio_data); end
      n_tests++;
      if (bus.pio_status !== 8'h81) begin n_fail++; $display("FAIL single_status got %h want 81", bus.pio_status); end
      bus.req = '0;
      tick();
      n_tests++;
      if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_pulse got %b want 0000", bus.grant); end
      tick();
      tick();
      tick();
      n_tests++;
      if (bus.pio_status !== 8'h81) begin n_fail++; $display("FAIL single_hold got %h want 81", bus.pio_status); end
      bus.ack_toggle = ~bus.ack_toggle;
      tick();
      n_tests++;
      if (bus.pio_status !== 8'h80) begin n_fail++; $display("FAIL single_ack_status got %h want 80", bus.pio_status); end
      tick();
      n_tests++;
      if (bus.pio_data !== 16'h1234 || bus.pio_status !== 8'h80) begin
         n_fail++; $display("FAIL single_idle_hold got data %h status %h want 1234 80", bus.pio_data, bus.pio_status);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      logic [7:0] exp_st;
      bit         seen;
      do_reset();
      bus.req = 4'b1111;
      bus.req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      for (int i = 0; i < 5; i++) begin
         seen = 1'b0;
         for (int w = 0; w < 8 && !seen; w++) begin
            tick();
            if (bus.grant !== 4'b0000) seen = 1'b1;
         end
         exp_g  = 4'b0001 << (i % 4);
         exp_st = {(i % 2 == 0) ? 1'b1 : 1'b0, 4'b0000, 2'(i % 4), 1'b1};
         n_tests++;
         if (!seen) begin n_fail++; $display("FAIL rr_wait[%0d] no grant within 8 cycles", i); end
         n_tests++;
         if (bus.grant !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", i, bus.grant, exp_g); end
         n_tests++;
         if (bus.pio_status !== exp_st) begin n_fail++; $display("FAIL rr_status[%0d] got %h want %h", i, bus.pio_status, exp_st); end
         n_tests++;
         if (bus.pio_data !== 16'hA000 + 16'(i % 4)) begin
            n_fail++; $display("FAIL rr_data[%0d] got %h want %h", i, bus.pio_data, 16'hA000 + 16'(i % 4));
         end
         tick();
         tick();
         bus.ack_toggle = ~bus.ack_toggle;
         tick();
         n_tests++;
         if (bus.pio_status[0] !== 1'b0) begin n_fail++; $display("FAIL rr_valid_drop[%0d] got %b want 0", i, bus.pio_status[0]); end
      end
      bus.req = '0;
   endtask

   task automatic test_timeout();
      int drop_at;
      do_reset();
      bus.req = 4'b0100;
      bus.req_data = {16'h0, 16'h5A5A, 16'h0, 16'h0};
      tick();
      n_tests++;
      if (bus.grant !== 4'b0100 || bus.pio_status !== 8'h85) begin
         n_fail++; $display("FAIL to_capture got grant %b status %h want 0100 85", bus.grant, bus.pio_status);
      end
      bus.req = '0;
      drop_at = -1;
      for (int k = 1; k <= 12 && drop_at < 0; k++) begin
         tick();
         if (bus.pio_status[0] === 1'b0) drop_at = k;
      end
      n_tests++;
      if (drop_at != 8) begin n_fail++; $display("FAIL to_latency got %0d want 8", drop_at); end
      n_tests++;
      if (bus.pio_status !== 8'h8C) begin n_fail++; $display("FAIL to_status got %h want 8c", bus.pio_status); end
      tick();
      tick();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      n_tests++;
      if (bus.pio_status !== 8'h84) begin n_fail++; $display("FAIL to_clr got %h want 84", bus.pio_status); end
      bus.ack_toggle = ~bus.ack_toggle;
      tick();
      tick();
      n_tests++;
      if (bus.pio_status !== 8'h84 || bus.grant !== 4'b0000 || bus.pio_data !== 16'h5A5A) begin
         n_fail++; $display("FAIL to_idle_ack got status %h grant %b data %h want 84 0000 5a5a",
                            bus.pio_status, bus.grant, bus.pio_data);
      end
      // second timeout with clr_err on the firing cycle: set must win
      bus.req = 4'b0100;
      tick();
      bus.req = '0;
      n_tests++;
      if (bus.pio_status !== 8'h05) begin n_fail++; $display("FAIL to2_capture got %h want 05", bus.pio_status); end
      for (int k = 1; k <= 7; k++) tick();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      n_tests++;
      if (bus.pio_status !== 8'h0C) begin n_fail++; $display("FAIL to_set_wins got %h want 0c", bus.pio_status); end
   endtask

   task automatic test_collision();
      do_reset();
      bus.req = 4'b0010;
      bus.req_data = {16'h0, 16'h0, 16'h0C0C, 16'h0};
      tick();
      bus.req = '0;
      n_tests++;
      if (bus.pio_status !== 8'h83) begin n_fail++; $display("FAIL col_capture got %h want 83", bus.pio_status); end
      for (int k = 1; k <= 7; k++) tick();
      n_tests++;
      if (bus.pio_status[0] !== 1'b1) begin n_fail++; $display("FAIL col_still_valid got %b want 1", bus.pio_status[0]); end
      bus.ack_toggle = ~bus.ack_toggle;
      tick();
      n_tests++;
      if (bus.pio_status !== 8'h82) begin n_fail++; $display("FAIL col_ack_wins got %h want 82", bus.pio_status); end
      tick();
      tick();
      n_tests++;
      if (bus.pio_status !== 8'h82) begin n_fail++; $display("FAIL col_idle got %h want 82", bus.pio_status); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req = 4'b0010;
      bus.req_data = {16'h0, 16'h0, 16'hBEEF, 16'h0};
      tick();
      bus.req = '0;
      n_tests++;
      if (bus.pio_data !== 16'hBEEF) begin n_fail++; $display("FAIL rm_capture got %h want beef", bus.pio_data); end
      tick();
      tick();
      reset = 1'b1;
      bus.req = 4'b1111;
      bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      tick();
      n_tests++;
      if (bus.pio_data !== 16'h0000 || bus.pio_status !== 8'h00 || bus.grant !== 4'b0000) begin
         n_fail++; $display("FAIL rm_reset got data %h status %h grant %b want 0000 00 0000",
                            bus.pio_data, bus.pio_status, bus.grant);
      end
      reset = 1'b0;
      tick();
      n_tests++;
      if (bus.grant !== 4'b0001 || bus.pio_data !== 16'h1111 || bus.pio_status !== 8'h81) begin
         n_fail++; $display("FAIL rm_first got grant %b data %h status %h want 0001 1111 81",
                            bus.grant, bus.pio_data, bus.pio_status);
      end
      bus.req = '0;
   endtask

   task automatic test_ack_early();
      do_reset();
      bus.req = 4'b0001;
      bus.req_data = {16'h0, 16'h2222, 16'h0, 16'h7777};
      tick();
      n_tests++;
      if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL ae_grant got %b want 0001", bus.grant); end
      bus.req = '0;
      tick();
      bus.ack_toggle = ~bus.ack_toggle;
      tick();
      n_tests++;
      if (bus.pio_status[0] !== 1'b0 || bus.grant !== 4'b0000) begin
         n_fail++; $display("FAIL ae_holdoff got valid %b grant %b want 0 0000", bus.pio_status[0], bus.grant);
      end
      bus.req = 4'b0100;
      tick();
      n_tests++;
      if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL ae_idle got %b want 0000", bus.grant); end
      tick();
      bus.req = '0;
      n_tests++;
      if (bus.grant !== 4'b0100 || bus.pio_data !== 16'h2222) begin
         n_fail++; $display("FAIL ae_next got grant %b data %h want 0100 2222", bus.grant, bus.pio_data);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1;
      bus.req = '0;
      bus.req_data = '0;
      bus.ack_toggle = 1'b0;
      bus.clr_err = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_collision();
      test_reset_mid();
      test_ack_early();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
